tohost_responder: RTL and testbench

TOHOST_RESPONDER -- requirements
Module: tohost_responder

---
 rtl/tohost_store_if.sv | 11 +
 rtl/tohost_responder.sv | 110 +++++++++++
 tb/tb_tohost_responder.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/tohost_store_if.sv
// Store channel from the core into the tohost responder: a valid/ready
// request carrying a word address and data.
interface tohost_store_if;
    logic        wr_valid;
    logic        wr_ready;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;

    modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
    modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);
endinterface

// File: rtl/tohost_responder.sv
// End-of-test monitor: watches tohost stores, the halt PC and a RUN-cycle
// budget, and latches a sticky PASS / FAIL / TIMEOUT verdict.
module tohost_responder #(
    parameter logic [31:0] TOHOST_ADDR = 32'h0000_1000,
    parameter logic [31:0] HALT_PC     = 32'h0000_0044,
    parameter int unsigned TIMEOUT     = 5000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    tohost_store_if.slave       st,
    input  logic [31:0]         pc_in,
    input  logic [31:0]         gp_in,
    output logic [2:0]          state,
    output logic                done,
    output logic                pass,
    output logic [30:0]         fail_code,
    output logic                timeout,
    output logic [31:0]         cycle_count
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RUN     = 3'd1,
        S_PASS    = 3'd2,
        S_FAIL    = 3'd3,
        S_TIMEOUT = 3'd4
    } state_e;

    localparam logic [31:0] TIMEOUT_W = 32'(TIMEOUT);

    state_e      state_q, state_d;
    logic        done_q, done_d;
    logic        pass_q, pass_d;
    logic        timeout_q, timeout_d;
    logic        wr_ready_q, wr_ready_d;
    logic [30:0] fail_code_q, fail_code_d;
    logic [31:0] count_q, count_d;
    logic        accept;
    logic        tohost_verdict;

    assign accept         = st.wr_valid & wr_ready_q;
    // Only odd data written to tohost is a verdict; even data is a console/ignored write.
    assign tohost_verdict = accept && (st.wr_addr == TOHOST_ADDR) && st.wr_data[0];

    always_comb begin
        state_d     = state_q;
        fail_code_d = fail_code_q;
        count_d     = count_q;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_RUN;
            end
            S_RUN: begin
                count_d = count_q + 32'd1;
                if (tohost_verdict) begin
                    if (st.wr_data == 32'd1) begin
                        state_d = S_PASS;
                    end else begin
                        state_d     = S_FAIL;
                        fail_code_d = st.wr_data[31:1];
                    end
                end else if (pc_in == HALT_PC) begin
                    if (gp_in == 32'd1) begin
                        state_d = S_PASS;
                    end else begin
                        state_d     = S_FAIL;
                        fail_code_d = gp_in[31:1];
                    end
                end else if (count_d >= TIMEOUT_W) begin
                    state_d = S_TIMEOUT;
                end
            end
            default: ;
        endcase
        done_d     = (state_d == S_PASS) || (state_d == S_FAIL) || (state_d == S_TIMEOUT);
        pass_d     = (state_d == S_PASS);
        timeout_d  = (state_d == S_TIMEOUT);
        wr_ready_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            timeout_q   <= 1'b0;
            wr_ready_q  <= 1'b0;
            fail_code_q <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            timeout_q   <= timeout_d;
            wr_ready_q  <= wr_ready_d;
            fail_code_q <= fail_code_d;
            count_q     <= count_d;
        end
    end

    assign st.wr_ready = wr_ready_q;
    assign state       = state_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign timeout     = timeout_q;
    assign fail_code   = fail_code_q;
    assign cycle_count = count_q;

endmodule

// File: tb/tb_tohost_responder.sv
// Bench for tohost_responder: directed scenarios, a verdict-level reference
// model compared every cycle, and literal spot checks.
module tb_tohost_responder;
    localparam logic [31:0] TH_ADDR = 32'h0000_1000;
    localparam logic [31:0] H_PC    = 32'h0000_0044;
    localparam int          TMO     = 20;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [31:0] pc_in = '0;
    logic [31:0] gp_in = '0;
    logic [2:0]  state;
    logic        done, pass, timeout;
    logic [30:0] fail_code;
    logic [31:0] cycle_count;

    tohost_store_if bus ();

    tohost_responder #(.TOHOST_ADDR(TH_ADDR), .HALT_PC(H_PC), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .start(start), .st(bus),
        .pc_in(pc_in), .gp_in(gp_in), .state(state), .done(done), .pass(pass),
        .fail_code(fail_code), .timeout(timeout), .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: phase 0 idle, 1 running, 2 pass, 3 fail, 4 timeout.
    int          m_phase = 0;
    int unsigned m_count = 0;
    logic [31:0] m_status = '0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_phase = 0; m_count = 0; m_status = '0;
        end else if (m_phase == 0) begin
            if (start) m_phase = 1;
        end else if (m_phase == 1) begin
            m_count = m_count + 1;
            if (bus.wr_valid && bus.wr_addr == TH_ADDR && (bus.wr_data % 2 == 1)) begin
                m_status = bus.wr_data;
                m_phase  = (bus.wr_data == 1) ? 2 : 3;
            end else if (pc_in == H_PC) begin
                m_status = gp_in;
                m_phase  = (gp_in == 1) ? 2 : 3;
            end else if (m_count == TMO) begin
                m_phase = 4;
            end
        end
    end

    logic [69:0] exp_vec, act_vec;
    always @(negedge clk) begin
        exp_vec = {3'(m_phase), (m_phase >= 2), (m_phase == 2),
                   (m_phase == 3) ? 31'(m_status / 2) : 31'd0,
                   (m_phase == 4), 32'(m_count), (m_phase != 0)};
        act_vec = {state, done, pass, fail_code, timeout, cycle_count, bus.wr_ready};
        n_total++;
        if (act_vec === exp_vec) n_pass++;
        else $display("FAIL model_cmp t=%0t got=%h expected=%h", $time, act_vec, exp_vec);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s got=%h expected=%h", name, act, exp);
    endtask

    task automatic cyc(input logic s, input logic v, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] pc, input logic [31:0] gp);
        @(negedge clk); #1;
        start = s; bus.wr_valid = v; bus.wr_addr = a; bus.wr_data = d; pc_in = pc; gp_in = gp;
        $display("txn t=%0t start=%0d valid=%0d addr=%h data=%h pc=%h gp=%h", $time, s, v, a, d, pc, gp);
        @(posedge clk); #1;
        start = 0; bus.wr_valid = 0; bus.wr_addr = '0; bus.wr_data = '0; pc_in = '0; gp_in = '0;
    endtask

    task automatic quiet(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 32'h0, 32'h0, 32'h0, 32'h0);
    endtask

    task automatic do_reset();
        @(negedge clk); #2 rst = 0;
        @(negedge clk); #2 rst = 1;
    endtask

    initial begin
        bus.wr_valid = 0; bus.wr_addr = '0; bus.wr_data = '0;
        repeat (2) @(negedge clk);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_ready", 32'(bus.wr_ready), 32'd0);
        #2 rst = 1;

        // Store verdict at RUN cycle 10
        cyc(1, 0, 0, 0, 0, 0);
        quiet(9);
        cyc(0, 1, TH_ADDR, 32'h1, 0, 0);
        chk("pass_state", 32'(state), 32'd2);
        chk("pass_count", cycle_count, 32'd10);
        chk("pass_flags", {29'd0, done, pass, timeout}, 32'b110);
        do_reset();

        // Failing status sticks against a later pass write
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 1, TH_ADDR, 32'h7, 0, 0);
        chk("fail_state", 32'(state), 32'd3);
        chk("fail_code7", 32'(fail_code), 32'd3);
        cyc(0, 1, TH_ADDR, 32'h1, 0, 0);
        chk("fail_sticky", 32'(state), 32'd3);
        do_reset();

        // Halt PC with gp=1, then gp=5
        cyc(1, 0, 0, 0, 0, 0);
        quiet(2);
        cyc(0, 0, 0, 0, H_PC, 32'd1);
        chk("halt_pass", 32'(state), 32'd2);
        do_reset();
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, H_PC, 32'd5);
        chk("halt_fail", 32'(state), 32'd3);
        chk("halt_code", 32'(fail_code), 32'd2);
        do_reset();

        // Store wins over halt PC in the same cycle
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 1, TH_ADDR, 32'h1, H_PC, 32'd9);
        chk("prio_pass", 32'(state), 32'd2);
        do_reset();

        // Dropped stores, then timeout at cycle 20
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 1, TH_ADDR, 32'h2, 0, 0);
        cyc(0, 1, 32'h2000, 32'h1, 0, 0);
        chk("drop_state", 32'(state), 32'd1);
        chk("drop_count", cycle_count, 32'd2);
        quiet(17);
        chk("pre_tmo_state", 32'(state), 32'd1);
        quiet(1);
        chk("tmo_state", 32'(state), 32'd4);
        chk("tmo_count", cycle_count, 32'd20);
        chk("tmo_flag", 32'(timeout), 32'd1);
        cyc(0, 1, 32'h2000, 32'h1, 0, 0);
        cyc(0, 1, TH_ADDR, 32'h2, 0, 0);
        cyc(1, 1, TH_ADDR, 32'h1, H_PC, 32'd1);
        chk("tmo_sticky", 32'(state), 32'd4);
        chk("tmo_count_hold", cycle_count, 32'd20);
        do_reset();

        // Asynchronous reset mid-RUN, then store while idle
        cyc(1, 0, 0, 0, 0, 0);
        quiet(3);
        chk("run_count", cycle_count, 32'd3);
        @(negedge clk); #2 rst = 0;
        #1;
        chk("async_state", 32'(state), 32'd0);
        chk("async_count", cycle_count, 32'd0);
        chk("async_ready", 32'(bus.wr_ready), 32'd0);
        @(negedge clk); #2 rst = 1;
        cyc(0, 1, TH_ADDR, 32'h1, 0, 0);
        chk("idle_state", 32'(state), 32'd0);
        chk("idle_ready", 32'(bus.wr_ready), 32'd0);
        quiet(2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
